dff: RTL and testbench

DFF -- requirements
Module: dff

---
 rtl/dff.sv | 27 ++
 tb/tb_dff.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dff.sv
// Parameterised D flip-flop with a synchronous, active-high reset and a
// complemented output. Drop-in replacement for the legacy dff, so the port
// order (q, qb, d, rst, clk) must not change.
module dff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    input  logic [WIDTH-1:0] d,
    input  logic             rst,
    input  logic             clk
);

    // Capture d on every rising edge; reset wins over d and only acts at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

    // The complement is taken from the register so it never lags q or sees d.
    assign qb = ~q;

endmodule

// File: tb/tb_dff.sv
// Directed bench for dff: a default 1-bit instance and a 4-bit instance with
// a non-zero reset value, driven from a shared vector table plus hand-written
// sequences for mid-cycle reset and between-edge data changes.
module tb_dff;

    localparam logic [3:0] WIDE_RST = 4'b1010;

    logic       clk;
    logic       rst;
    logic       d;
    logic [3:0] dw;
    logic       q;
    logic       qb;
    logic [3:0] qw;
    logic [3:0] qbw;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       d;
        logic [3:0] dw;
        logic       expQ;
        logic [3:0] expQw;
    } vector_t;

    vector_t vecs [9];

    dff dut (
        .q  (q),
        .qb (qb),
        .d  (d),
        .rst(rst),
        .clk(clk)
    );

    dff #(.WIDTH(4), .RST_VAL(WIDE_RST)) dutw (
        .q  (qw),
        .qb (qbw),
        .d  (dw),
        .rst(rst),
        .clk(clk)
    );

    // Free-running clock, period 10 ns, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic dv, input logic [3:0] dwv);
        rst = r;
        d   = dv;
        dw  = dwv;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both instances against the expected narrow and wide q values.
    task automatic checkAll(input string tag, input logic eq, input logic [3:0] eqw);
        logic eqb;
        eqb = ~eq;
        checkOutput({tag, "_q"},   {3'b000, q},  {3'b000, eq});
        checkOutput({tag, "_qb"},  {3'b000, qb}, {3'b000, eqb});
        checkOutput({tag, "_qw"},  qw,  eqw);
        checkOutput({tag, "_qbw"}, qbw, ~eqw);
    endtask

    initial begin
        // rst, d, dw, expected q, expected wide q (rst ? reset value : d)
        vecs[0] = '{1'b1, 1'b0, 4'h0, 1'b0, WIDE_RST};
        vecs[1] = '{1'b0, 1'b0, 4'h3, 1'b0, 4'h3};
        vecs[2] = '{1'b0, 1'b0, 4'h5, 1'b0, 4'h5};
        vecs[3] = '{1'b0, 1'b1, 4'hF, 1'b1, 4'hF};
        vecs[4] = '{1'b0, 1'b1, 4'hF, 1'b1, 4'hF};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
        vecs[6] = '{1'b0, 1'b1, 4'hC, 1'b1, 4'hC};
        vecs[7] = '{1'b1, 1'b1, 4'h6, 1'b0, WIDE_RST};
        vecs[8] = '{1'b0, 1'b1, 4'h9, 1'b1, 4'h9};

        // Vector 0 is driven at time 0 and each later one right after a falling
        // edge; the result is sampled at the following falling edge.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].d, vecs[i].dw);
            @(negedge clk);
            checkAll($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expQw);
        end

        // Mid-cycle reset: q is 1, d stays 1, rst rises between edges.
        applyStimulus(1'b0, 1'b1, 4'h7);
        @(posedge clk);
        #1;
        checkAll("pre_rst", 1'b1, 4'h7);
        #2;
        applyStimulus(1'b1, 1'b1, 4'h7);
        #1;
        checkAll("rst_between_edges", 1'b1, 4'h7);
        @(negedge clk);
        checkAll("rst_still_pending", 1'b1, 4'h7);
        @(posedge clk);
        #1;
        checkAll("rst_taken", 1'b0, WIDE_RST);

        // Data toggling between edges must not reach the outputs.
        applyStimulus(1'b0, 1'b0, 4'h2);
        @(posedge clk);
        #1;
        checkAll("toggle_base", 1'b0, 4'h2);
        for (int k = 0; k < 4; k++) begin
            #1;
            applyStimulus(1'b0, ~d, dw + 4'h1);
            #1;
            checkAll($sformatf("toggle%0d", k), 1'b0, 4'h2);
        end
        // Final values before the edge: d = 0 after four inversions, dw = 6.
        @(posedge clk);
        #1;
        checkAll("toggle_capture", 1'b0, 4'h6);
        applyStimulus(1'b0, 1'b1, 4'hB);
        @(posedge clk);
        #1;
        checkAll("toggle_capture2", 1'b1, 4'hB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
